// File: rtl/line_dirty_tracker.sv
// line_dirty_tracker: per-pixel dirty flags in three rotating banks (update / read / clear).
// Optional macro LINE_DIRTY_COUNT_EN adds a per-line count of newly dirtied pixels.
module line_dirty_tracker #(
    parameter int LINE_PIXELS = 640,
    parameter int PACK        = 4,
    parameter int A_W         = 8,
    parameter int X_W         = 10,
    parameter int CNT_W       = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             line_start,
    input  logic [A_W-1:0]   wr_addr,
    input  logic             wr_en,
    input  logic [PACK-1:0]  wr_mask,
    output logic [PACK-1:0]  upd_flags,
    input  logic [X_W-1:0]   x,
    output logic             enable,
    output logic             clear_busy,
    output logic             clear_done,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             init_busy
`ifdef LINE_DIRTY_COUNT_EN
    ,
    output logic [CNT_W-1:0] dirty_count
`endif
);
    localparam int WORDS = LINE_PIXELS / PACK;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
    localparam logic [X_W-1:0] PK = X_W'(PACK);

    logic [PACK-1:0] bank [3][WORDS];
    logic [1:0]      sel, upd_b, rd_b;
    logic [IW-1:0]   ptr, wr_idx, x_idx;
    logic [X_W-1:0]  x_word, x_bit;
    logic            wr_ok, x_ok, ls, upd_we, clr_we;
    logic [PACK-1:0] upd_word, rd_sh;

    // role decode and combinational read ports; line_start is ignored during init
    always_comb begin
        upd_b     = sel == 2'd0 ? 2'd2 : sel == 2'd1 ? 2'd0 : 2'd1;
        rd_b      = sel == 2'd0 ? 2'd1 : sel == 2'd1 ? 2'd2 : 2'd0;
        wr_ok     = {1'b0, wr_addr} < (A_W + 1)'(WORDS);
        x_ok      = {1'b0, x} < (X_W + 1)'(LINE_PIXELS);
        wr_idx    = wr_addr[IW-1:0];
        x_word    = x / PK;
        x_bit     = x % PK;
        x_idx     = x_word[IW-1:0];
        ls        = line_start & ~init_busy;
        upd_we    = wr_en & wr_ok & ~init_busy;
        clr_we    = clear_busy & ~ls;
        upd_word  = bank[upd_b][wr_idx];
        upd_flags = (rst && wr_ok) ? upd_word : '0;
        rd_sh     = bank[rd_b][x_idx] >> x_bit;
        enable    = rst & x_ok & ~init_busy & rd_sh[0];
    end

    // draw-side OR-merge plus sweep zeroing (all banks during init); arrays are not reset
    always_ff @(posedge clk) begin
        if (upd_we)
            bank[upd_b][wr_idx] <= upd_word | wr_mask;
        for (int b = 0; b < 3; b++)
            if (clr_we && (init_busy || sel == b[1:0]))
                bank[b][ptr] <= '0;
    end

    // rotation, clear sweep / init sequencing and sticky overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel        <= 2'd0;
            ptr        <= '0;
            clear_busy <= 1'b1;
            init_busy  <= 1'b1;
            clear_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            if (ls) begin
                sel        <= sel == 2'd2 ? 2'd0 : sel + 2'd1;
                clear_busy <= 1'b1;
                ptr        <= '0;
            end else if (clear_busy) begin
                ptr <= ptr + 1'b1;
                if (ptr == LAST) begin
                    ptr        <= '0;
                    clear_busy <= 1'b0;
                    init_busy  <= 1'b0;
                    clear_done <= 1'b1;
                end
            end
            if (ls && clear_busy)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

`ifdef LINE_DIRTY_COUNT_EN
    logic [CNT_W-1:0] cnt, add, inc, sat;
    logic [CNT_W:0]   sum;

    // newly dirtied pixels of this write, saturating accumulation
    always_comb begin
        add = '0;
        for (int i = 0; i < PACK; i++)
            add = add + CNT_W'(wr_mask[i] & ~upd_word[i]);
        inc = upd_we ? add : '0;
        sum = {1'b0, cnt} + {1'b0, inc};
        sat = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    // latch the line's count on line_start and restart the counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            dirty_count <= '0;
        end else if (ls) begin
            dirty_count <= sat;
            cnt         <= '0;
        end else begin
            cnt <= sat;
        end
    end
`endif
endmodule

// File: tb/tb_line_dirty_tracker.sv
// tb_line_dirty_tracker: random + directed checks against a pixel-level bank model.
module tb_line_dirty_tracker;
    localparam int LP = 640, PK = 4, WD = LP / PK, AW = 8, XW = 10, CW = 11;

    logic clk = 0, rst = 1, line_start = 0, wr_en = 0, overrun_clr = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [PK-1:0] wr_mask = '0;
    logic [XW-1:0] x = '0;
    logic [PK-1:0] upd_flags;
    logic enable, clear_busy, clear_done, overrun, init_busy;
`ifdef LINE_DIRTY_COUNT_EN
    logic [CW-1:0] dirty_count;
`endif

    line_dirty_tracker dut (
        .clk(clk), .rst(rst), .line_start(line_start), .wr_addr(wr_addr), .wr_en(wr_en),
        .wr_mask(wr_mask), .upd_flags(upd_flags), .x(x), .enable(enable),
        .clear_busy(clear_busy), .clear_done(clear_done), .overrun(overrun),
        .overrun_clr(overrun_clr), .init_busy(init_busy)
`ifdef LINE_DIRTY_COUNT_EN
        , .dirty_count(dirty_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // model: one flag per pixel per bank; mk marks banks whose contents are known
    bit mf [3][LP];
    bit mk [3];
    int m_sel, m_left, m_cnt, m_dc;
    bit m_busy, m_init, m_done, m_ovr, m_cnt_ok, m_dc_ok;

    function automatic int ub(); return (m_sel + 2) % 3; endfunction
    function automatic int rb(); return (m_sel + 1) % 3; endfunction

    task automatic model_reset();
        m_sel = 0; m_busy = 1; m_init = 1; m_left = WD; m_done = 0; m_ovr = 0;
        m_cnt = 0; m_dc = 0; m_cnt_ok = 1; m_dc_ok = 1;
        for (int b = 0; b < 3; b++) mk[b] = 0;
    endtask

    task automatic model_tick();
        int u;
        bit ls;
        u = ub();
        ls = line_start && !m_init;
        if (wr_en && !m_init && wr_addr < WD) begin
            if (!mk[u]) m_cnt_ok = 0;
            for (int i = 0; i < PK; i++)
                if (wr_mask[i] && !mf[u][wr_addr * PK + i]) begin
                    mf[u][wr_addr * PK + i] = 1;
                    m_cnt = m_cnt < 2047 ? m_cnt + 1 : 2047;
                end
        end
        m_done = 0;
        if (ls && m_busy) m_ovr = 1;
        else if (overrun_clr) m_ovr = 0;
        if (ls) begin
            if (m_busy) mk[m_sel] = 0;
            m_dc = m_cnt; m_dc_ok = m_cnt_ok; m_cnt = 0; m_cnt_ok = 1;
            m_sel = (m_sel + 1) % 3; m_busy = 1; m_left = WD;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1;
                for (int b = 0; b < 3; b++)
                    if (m_init || b == m_sel) begin
                        mk[b] = 1;
                        for (int p = 0; p < LP; p++) mf[b][p] = 0;
                    end
                m_init = 0;
            end
        end
    endtask

    task automatic cyc(input bit ls, input bit we, input int a, input int msk, input int xx, input bit oc);
        int r, u, e;
        line_start = ls; wr_en = we; wr_addr = AW'(a); wr_mask = PK'(msk); x = XW'(xx); overrun_clr = oc;
        #1;
        r = rb(); u = ub();
        if (x >= LP || m_init) chk("enable", enable, 0);
        else if (mk[r]) chk("enable", enable, mf[r][x]);
        if (wr_addr >= WD) chk("upd_flags", upd_flags, 0);
        else if (mk[u]) begin
            e = 0;
            for (int i = 0; i < PK; i++) e |= int'(mf[u][wr_addr * PK + i]) << i;
            chk("upd_flags", upd_flags, e);
        end
        model_tick();
        @(posedge clk); #1;
        chk("clear_busy", clear_busy, m_busy);
        chk("clear_done", clear_done, m_done);
        chk("overrun", overrun, m_ovr);
        chk("init_busy", init_busy, m_init);
`ifdef LINE_DIRTY_COUNT_EN
        if (m_dc_ok) chk("dirty_count", dirty_count, m_dc);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, $urandom_range(0, LP + 10), 0);
    endtask

    task automatic lat(input string tag);
        int n;
        n = 0;
        for (int k = 0; k < 400; k++) begin
            idle(1);
            n++;
            if (clear_done) break;
        end
        chk(tag, n, WD);
    endtask

    task automatic probe(input int xx, input int e);
        line_start = 0; wr_en = 0; overrun_clr = 0; x = XW'(xx);
        #1;
        chk("en_probe", enable, e);
        cyc(0, 0, 0, 0, xx, 0);
    endtask

    task automatic do_reset(input int n);
        rst = 0; line_start = 0; wr_en = 0; overrun_clr = 0;
        model_reset();
        repeat (n) begin
            @(posedge clk); #1;
            x = XW'($urandom_range(0, LP - 1)); wr_addr = AW'($urandom_range(0, WD - 1));
            #1;
            chk("rst_init_busy", init_busy, 1);
            chk("rst_clear_busy", clear_busy, 1);
            chk("rst_clear_done", clear_done, 0);
            chk("rst_overrun", overrun, 0);
            chk("rst_enable", enable, 0);
            chk("rst_upd_flags", upd_flags, 0);
        end
        rst = 1;
    endtask

    initial begin
        do_reset(3);
        lat("init_len");
        for (int i = 0; i <= LP; i++) cyc(0, 0, 0, 0, i, 0);
        cyc(0, 1, 5, 4'b0101, 0, 0);
        cyc(0, 1, 5, 4'b0010, 0, 0);
        wr_en = 0; wr_addr = 5; #1;
        chk("upd_5", upd_flags, 4'b0111);
        cyc(1, 0, 0, 0, 0, 0);
        probe(20, 1); probe(21, 1); probe(22, 1); probe(23, 0); probe(640, 0);
        repeat (3) begin
            cyc(1, 0, 0, 0, 20, 0);
            lat("done_lat");
            idle(40);
        end
        cyc(1, 0, 0, 0, 0, 0);
        idle(49);
        cyc(1, 0, 0, 0, 0, 0);
        chk("ovr_set", overrun, 1);
        idle(10);
        chk("ovr_hold", overrun, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("ovr_clr", overrun, 0);
        idle(200);
        cyc(1, 0, 0, 0, 0, 0);
        idle(49);
        cyc(1, 0, 0, 0, 0, 1);
        chk("ovr_set_wins", overrun, 1);
        cyc(0, 0, 0, 0, 0, 1);
        repeat (3) begin
            idle(200);
            cyc(1, 0, 0, 0, 0, 0);
        end
        idle(200);
        cyc(1, 1, 3, 4'b1000, 0, 0);
        probe(15, 1);
        probe(14, 0);
`ifdef LINE_DIRTY_COUNT_EN
        idle(200);
        cyc(0, 1, 7, 4'b1111, 0, 0);
        cyc(0, 1, 7, 4'b1111, 0, 0);
        cyc(0, 1, 9, 4'b0001, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("dirty_5", dirty_count, 5);
`endif
        repeat (16) begin
            int gap;
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 150) : $urandom_range(165, 260);
            cyc(1, $urandom_range(0, 1), $urandom_range(0, WD + 10), $urandom, $urandom_range(0, LP + 20), 0);
            repeat (gap)
                cyc(0, $urandom_range(0, 2) == 0, $urandom_range(0, WD + 10), $urandom,
                    $urandom_range(0, LP + 20), $urandom_range(0, 30) == 0);
        end
        idle(200);
        cyc(1, 0, 0, 0, 0, 0);
        idle(20);
        do_reset(3);
        lat("reinit_len");
        repeat (300)
            cyc($urandom_range(0, 150) == 0, $urandom_range(0, 1), $urandom_range(0, WD + 10), $urandom,
                $urandom_range(0, LP + 20), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
